// File: rtl/dispatch_ctrl_pkg.sv
// Shared widths, opcode constants, FSM/class encodings and the issue payload for dispatch_ctrl.
package dispatch_ctrl_pkg;

  localparam int unsigned TAG_W   = 4;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_W    = 7;
  localparam int unsigned REG_W   = 5;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OP_W-1:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ISSUE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_ILL = 2'd0,
    CLS_RS  = 2'd1,
    CLS_LSB = 2'd2
  } cls_e;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic [PC_W-1:0]    pc;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [INSTR_W-1:0] imm;
  } issue_t;

  // Back-end destination of an opcode; anything unrecognised is illegal.
  function automatic cls_e classify(input logic [OP_W-1:0] op);
    case (op)
      OP_LOAD, OP_STORE: return CLS_LSB;
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_BRANCH, OP_IMM, OP_REG: return CLS_RS;
      default: return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/dispatch_ctrl_dc.sv
// Combinational RV32 field decoder: register indices and format-dependent immediate.
module dispatch_ctrl_dc
  import dispatch_ctrl_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [REG_W-1:0]   rd_c,
  output logic [REG_W-1:0]   rs1_c,
  output logic [REG_W-1:0]   rs2_c,
  output logic [INSTR_W-1:0] imm_c
);

  assign rd_c  = instr[11:7];
  assign rs1_c = instr[19:15];
  assign rs2_c = instr[24:20];

  always_comb begin
    imm_c = '0;
    case (instr[6:0])
      OP_LOAD, OP_IMM, OP_JALR: imm_c = {{20{instr[31]}}, instr[31:20]};
      OP_STORE:                 imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_BRANCH:                imm_c = {{19{instr[31]}}, instr[31], instr[7],
                                         instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm_c = {instr[31:12], 12'b0};
      OP_JAL:                   imm_c = {{11{instr[31]}}, instr[31], instr[19:12],
                                         instr[20], instr[30:21], 1'b0};
      default:                  imm_c = '0;
    endcase
  end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch sequencer: pops the instruction queue, holds the decoder input, registers the
// decoded fields and issues with a ROB tag to the RS or the LSB.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               iq_empty,
  input  logic [INSTR_W-1:0] iq_instr,
  input  logic [PC_W-1:0]    iq_pc,
  output logic               iq_pop,
  output logic [INSTR_W-1:0] dc_instr,
  output logic [PC_W-1:0]    dc_pc,
  input  logic [REG_W-1:0]   dc_rd,
  input  logic [REG_W-1:0]   dc_rs1,
  input  logic [REG_W-1:0]   dc_rs2,
  input  logic [INSTR_W-1:0] dc_imm,
  input  logic               rob_ready,
  input  logic               rs_ready,
  input  logic               lsb_ready,
  output logic               rob_valid,
  output logic               rs_valid,
  output logic               lsb_valid,
  output logic [OP_W-1:0]    is_op,
  output logic [2:0]         is_funct3,
  output logic               is_funct7b5,
  output logic [PC_W-1:0]    is_pc,
  output logic [REG_W-1:0]   is_rd,
  output logic [REG_W-1:0]   is_rs1,
  output logic [REG_W-1:0]   is_rs2,
  output logic [INSTR_W-1:0] is_imm,
  output logic [TAG_W-1:0]   is_tag,
  output logic               illegal
);

  state_e           state_q, state_d;
  cls_e             cls_q;
  issue_t           iss_q;
  logic [TAG_W-1:0] tag_q;
  logic             load_dc, load_is, tag_inc, adv, tgt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state, handshakes and datapath load enables; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    iq_pop    = 1'b0;
    rob_valid = 1'b0;
    rs_valid  = 1'b0;
    lsb_valid = 1'b0;
    illegal   = 1'b0;
    load_dc   = 1'b0;
    load_is   = 1'b0;
    tag_inc   = 1'b0;
    adv       = 1'b0;
    tgt_ready = (cls_q == CLS_LSB) ? lsb_ready : rs_ready;
    case (state_q)
      ST_IDLE: begin
        if (!flush && !iq_empty) begin
          iq_pop  = 1'b1;
          load_dc = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (!flush) begin
          load_is = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!flush) begin
          // Illegal opcodes retire on their own without touching the back end or the tag.
          if (cls_q == CLS_ILL) begin
            illegal = 1'b1;
            adv     = 1'b1;
          end else begin
            rob_valid = 1'b1;
            rs_valid  = (cls_q == CLS_RS);
            lsb_valid = (cls_q == CLS_LSB);
            adv       = rob_ready & tgt_ready;
            tag_inc   = adv;
          end
          if (adv) begin
            if (!iq_empty) begin
              iq_pop  = 1'b1;
              load_dc = 1'b1;
              state_d = ST_DECODE;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_instr <= '0;
      dc_pc    <= '0;
      iss_q    <= '0;
      cls_q    <= CLS_ILL;
      tag_q    <= '0;
    end else begin
      if (load_dc) begin
        dc_instr <= iq_instr;
        dc_pc    <= iq_pc;
      end
      if (load_is) begin
        iss_q <= '{op:       dc_instr[6:0],
                   funct3:   dc_instr[14:12],
                   funct7b5: dc_instr[30],
                   pc:       dc_pc,
                   rd:       dc_rd,
                   rs1:      dc_rs1,
                   rs2:      dc_rs2,
                   imm:      dc_imm};
        cls_q <= classify(dc_instr[6:0]);
      end
      if (flush)        tag_q <= '0;
      else if (tag_inc) tag_q <= tag_q + TAG_W'(1);
    end
  end

  assign is_op       = iss_q.op;
  assign is_funct3   = iss_q.funct3;
  assign is_funct7b5 = iss_q.funct7b5;
  assign is_pc       = iss_q.pc;
  assign is_rd       = iss_q.rd;
  assign is_rs1      = iss_q.rs1;
  assign is_rs2      = iss_q.rs2;
  assign is_imm      = iss_q.imm;
  assign is_tag      = tag_q;

endmodule
